// File: rtl/mac_kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_kbd_pkg
//  Description : Command/reply byte constants and FSM state type for the
//                Macintosh Plus keyboard link engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_kbd_pkg;

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;

    localparam logic [7:0] RSP_NULL    = 8'h7B;
    localparam logic [7:0] RSP_MODEL   = 8'h0B;
    localparam logic [7:0] RSP_ACK     = 8'h7D;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DELAY    = 2'd1,
        ST_WAIT_KEY = 2'd2,
        ST_REPLY    = 2'd3
    } kbd_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_kbd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mac_kbd_fifo
//  Description : Small synchronous first-word-fall-through key-code FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_kbd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int c_AW = $clog2(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wrPtr;
    logic [c_AW-1:0] r_rdPtr;
    logic [c_AW:0]   r_count;
    logic            w_doPush;
    logic            w_doPop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == (c_AW+1)'(DEPTH));
    assign dout     = r_mem[r_rdPtr];
    assign w_doPop  = pop & ~empty;
    // A pop frees the slot before the push lands, so full+pop+push is accepted
    assign w_doPush = push & (~full | w_doPop);

    always_ff @(posedge clk) begin
        if (w_doPush && !flush && !reset) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= r_count + {{c_AW{1'b0}}, w_doPush} - {{c_AW{1'b0}}, w_doPop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_kbd_link.sv
`default_nettype none
// ============================================================================
//  Module      : mac_kbd_link
//  Description : Keyboard-side protocol engine: command decode, reply timing,
//                inquiry deadline and key FIFO with sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_kbd_link #(
    parameter int FIFO_DEPTH    = 8,
    parameter int REPLY_DELAY   = 2048,
    parameter int INQUIRY_TICKS = 1958400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cen,
    input  logic [7:0] cmd_data,
    input  logic       cmd_strobe,
    input  logic [7:0] key_data,
    input  logic       key_strobe,
    output logic [7:0] reply_data,
    output logic       reply_strobe,
    output logic       overflow
);
    import mac_kbd_pkg::*;

    localparam int c_DLY_W = ($clog2(REPLY_DELAY + 1) > 12) ? $clog2(REPLY_DELAY + 1) : 12;
    localparam int c_INQ_W = 21;
    localparam logic [c_DLY_W-1:0] c_DLY_LOAD = c_DLY_W'(REPLY_DELAY - 1);
    localparam logic [c_INQ_W-1:0] c_INQ_LOAD = c_INQ_W'(INQUIRY_TICKS - 1);

    kbd_state_t         r_state;
    kbd_state_t         w_stateNext;
    logic [c_DLY_W-1:0] r_delayCnt;
    logic [c_DLY_W-1:0] w_delayNext;
    logic [c_INQ_W-1:0] r_inqCnt;
    logic [c_INQ_W-1:0] w_inqNext;
    logic [7:0]         r_cmd;
    logic [7:0]         w_cmdNext;
    logic               r_nullReply;
    logic               w_nullNext;
    logic [7:0]         r_replyHold;
    logic [7:0]         w_replyByte;
    logic               r_overflow;
    logic               w_pop;
    logic               w_flush;
    logic               w_cmdValid;
    logic [7:0]         w_fifoDout;
    logic               w_empty;
    logic               w_full;

    assign w_cmdValid = (cmd_data == CMD_INQUIRY) || (cmd_data == CMD_INSTANT) ||
                        (cmd_data == CMD_MODEL)   || (cmd_data == CMD_TEST);

    always_comb begin
        w_stateNext = r_state;
        w_delayNext = (r_delayCnt != '0) ? r_delayCnt - 1'b1 : r_delayCnt;
        w_inqNext   = (r_inqCnt != '0) ? r_inqCnt - 1'b1 : r_inqCnt;
        w_cmdNext   = r_cmd;
        w_nullNext  = r_nullReply;
        w_replyByte = r_replyHold;
        w_pop       = 1'b0;
        w_flush     = 1'b0;

        // The reply byte is resolved in the strobe cycle itself, from the FIFO head
        if (r_state == ST_REPLY) begin
            case (r_cmd)
                CMD_TEST:  w_replyByte = RSP_ACK;
                CMD_MODEL: w_replyByte = RSP_MODEL;
                default: begin
                    if (r_nullReply || w_empty) begin
                        w_replyByte = RSP_NULL;
                    end else begin
                        w_replyByte = w_fifoDout;
                        w_pop       = 1'b1;
                    end
                end
            endcase
        end

        case (r_state)
            ST_IDLE: begin
                w_stateNext = ST_IDLE;
            end
            ST_DELAY: begin
                if (r_delayCnt <= c_DLY_W'(1)) begin
                    // A key landing on the expiry edge is already in the FIFO at the reply
                    if (r_cmd == CMD_INQUIRY && w_empty && !key_strobe) begin
                        w_stateNext = ST_WAIT_KEY;
                    end else begin
                        w_stateNext = ST_REPLY;
                    end
                end
            end
            ST_WAIT_KEY: begin
                if (r_inqCnt <= c_INQ_W'(1)) begin
                    w_stateNext = ST_REPLY;
                    w_nullNext  = 1'b1;
                end else if (key_strobe) begin
                    w_stateNext = ST_REPLY;
                end
            end
            ST_REPLY: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase

        if (cmd_strobe) begin
            if (w_cmdValid) begin
                w_stateNext = ST_DELAY;
                w_delayNext = c_DLY_LOAD;
                w_inqNext   = c_INQ_LOAD;
                w_cmdNext   = cmd_data;
                w_nullNext  = 1'b0;
                w_flush     = (cmd_data == CMD_MODEL);
            end else begin
                w_stateNext = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_delayCnt  <= '0;
            r_inqCnt    <= '0;
            r_cmd       <= '0;
            r_nullReply <= 1'b0;
            r_replyHold <= '0;
            r_overflow  <= 1'b0;
        end else if (cen) begin
            r_state     <= w_stateNext;
            r_delayCnt  <= w_delayNext;
            r_inqCnt    <= w_inqNext;
            r_cmd       <= w_cmdNext;
            r_nullReply <= w_nullNext;
            r_replyHold <= w_replyByte;
            if (w_flush) begin
                r_overflow <= 1'b0;
            end else if (key_strobe && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    mac_kbd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cen & key_strobe),
        .pop   (cen & w_pop),
        .flush (cen & w_flush),
        .din   (key_data),
        .dout  (w_fifoDout),
        .empty (w_empty),
        .full  (w_full)
    );

    assign reply_data   = w_replyByte;
    assign reply_strobe = (r_state == ST_REPLY);
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mac_kbd_link.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_kbd_link
//  Description : Scoreboard bench for mac_kbd_link with a cycle-level reference
//                model built from the protocol timing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_kbd_link;
    localparam int D   = 4;
    localparam int T   = 64;
    localparam int DEP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cen = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_strobe = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       key_strobe = 1'b0;
    logic [7:0] reply_data;
    logic       reply_strobe;
    logic       overflow;

    mac_kbd_link #(
        .FIFO_DEPTH    (DEP),
        .REPLY_DELAY   (D),
        .INQUIRY_TICKS (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cen          (cen),
        .cmd_data     (cmd_data),
        .cmd_strobe   (cmd_strobe),
        .key_data     (key_data),
        .key_strobe   (key_strobe),
        .reply_data   (reply_data),
        .reply_strobe (reply_strobe),
        .overflow     (overflow)
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] mq[$];
    int         compared = 0;
    int         mism = 0;
    int         cenIdx = 0;
    bit         pend = 1'b0;
    int         pN = 0;
    logic [7:0] pType = 8'h00;
    bit         mOvf = 1'b0;
    bit         expOvf = 1'b0;

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (9) @(posedge clk);
            #1 cen = 1'b1;
            @(posedge clk);
            #1 cen = 1'b0;
        end
    end

    always @(posedge clk) if (cen) cenIdx++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: pops the scoreboard whenever the DUT strobes a reply
    always @(negedge clk) begin
        if (cen) begin
            if (reply_strobe) begin
                compared++;
                if (expQ.size() == 0 || expQ[0].cyc != cenIdx) begin
                    mism++;
                    $display("FAIL unexpected_strobe: strobe at cen %0d data %h, required none", cenIdx, reply_data);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    if (reply_data !== e.data) begin
                        mism++;
                        $display("FAIL reply_data: cen %0d got %h required %h", cenIdx, reply_data, e.data);
                    end
                end
            end else if (expQ.size() > 0 && expQ[0].cyc == cenIdx) begin
                exp_t e;
                e = expQ.pop_front();
                compared++;
                mism++;
                $display("FAIL missing_strobe: cen %0d got no strobe, required %h", cenIdx, e.data);
            end
            compared++;
            if (overflow !== expOvf) begin
                mism++;
                $display("FAIL overflow: cen %0d got %b required %b", cenIdx, overflow, expOvf);
            end
        end
    end

    function automatic bit isCmd(logic [7:0] b);
        return (b == 8'h10) || (b == 8'h14) || (b == 8'h16) || (b == 8'h36);
    endfunction

    // Reference: reply time/content follow from the command cycle N and key cycles
    task automatic modelStep(int e, bit cv, logic [7:0] cb, bit kv, logic [7:0] kb);
        bit flushed;
        flushed = 1'b0;
        if (pend) begin
            if (pType == 8'h10) begin
                if (e == pN + T) begin
                    expQ.push_back('{e, 8'h7B});
                    pend = 1'b0;
                end else if (e >= pN + D && mq.size() > 0) begin
                    expQ.push_back('{e, mq.pop_front()});
                    pend = 1'b0;
                end
            end else if (e == pN + D) begin
                if (pType == 8'h36)      expQ.push_back('{e, 8'h7D});
                else if (pType == 8'h16) expQ.push_back('{e, 8'h0B});
                else if (mq.size() > 0)  expQ.push_back('{e, mq.pop_front()});
                else                     expQ.push_back('{e, 8'h7B});
                pend = 1'b0;
            end
        end
        expOvf = mOvf;
        if (cv) begin
            if (isCmd(cb)) begin
                pend  = 1'b1;
                pN    = e;
                pType = cb;
                if (cb == 8'h16) begin
                    mq.delete();
                    mOvf    = 1'b0;
                    flushed = 1'b1;
                end
            end else begin
                pend = 1'b0;
            end
        end
        if (kv && !flushed) begin
            if (mq.size() < DEP) mq.push_back(kb);
            else                 mOvf = 1'b1;
        end
    endtask

    task automatic waitCen();
        do @(posedge clk); while (!cen);
        #2;
    endtask

    task automatic cycle(bit cv, logic [7:0] cb, bit kv, logic [7:0] kb);
        int e;
        e = cenIdx;
        cmd_strobe = cv;
        cmd_data   = cb;
        key_strobe = kv;
        key_data   = kb;
        modelStep(e, cv, cb, kv, kb);
        waitCen();
        cmd_strobe = 1'b0;
        key_strobe = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) cycle(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic chk(string nm, logic [7:0] act, logic [7:0] req);
        compared++;
        if (act !== req) begin
            mism++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        pend   = 1'b0;
        mOvf   = 1'b0;
        expOvf = 1'b0;
        mq.delete();
        chk("reset_data", reply_data, 8'h00);
        chk("reset_strobe", {7'd0, reply_strobe}, 8'h00);
        chk("reset_overflow", {7'd0, overflow}, 8'h00);
    endtask

    initial begin
        waitCen();
        waitCen();
        doReset();

        // Test command, then silence
        cycle(1'b1, 8'h36, 1'b0, 8'h00); idle(10);
        // Two keys drained by Instant, then empty Instant
        cycle(1'b0, 8'h00, 1'b1, 8'h21);
        cycle(1'b0, 8'h00, 1'b1, 8'h23);
        repeat (3) begin cycle(1'b1, 8'h14, 1'b0, 8'h00); idle(6); end
        // Inquiry answered by a late key, then Inquiry timing out
        cycle(1'b1, 8'h10, 1'b0, 8'h00); idle(19);
        cycle(1'b0, 8'h00, 1'b1, 8'h35); idle(5);
        cycle(1'b1, 8'h10, 1'b0, 8'h00); idle(70);
        // Overflow, then Model flush
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 8'(8'h41 + i));
        idle(2);
        cycle(1'b1, 8'h16, 1'b0, 8'h00); idle(6);
        cycle(1'b1, 8'h14, 1'b0, 8'h00); idle(6);
        // Abort by a second command
        cycle(1'b1, 8'h36, 1'b0, 8'h00); idle(1);
        cycle(1'b1, 8'h14, 1'b0, 8'h00); idle(8);
        // Reset in the middle of an Inquiry
        cycle(1'b1, 8'h10, 1'b0, 8'h00); idle(2);
        doReset();
        idle(70);
        // Full FIFO with pop and push in the same cycle
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 8'(8'h51 + i));
        cycle(1'b1, 8'h14, 1'b0, 8'h00); idle(3);
        cycle(1'b0, 8'h00, 1'b1, 8'h5A); idle(2);
        repeat (5) begin cycle(1'b1, 8'h14, 1'b0, 8'h00); idle(5); end
        // Push into empty FIFO in the Instant reply cycle stays queued
        cycle(1'b1, 8'h14, 1'b0, 8'h00); idle(3);
        cycle(1'b0, 8'h00, 1'b1, 8'h66); idle(2);
        cycle(1'b1, 8'h14, 1'b0, 8'h00); idle(6);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            bit         cv;
            bit         kv;
            logic [7:0] cb;
            logic [7:0] kb;
            cv = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 5))
                0:       cb = 8'h10;
                1:       cb = 8'h14;
                2:       cb = 8'h16;
                3:       cb = 8'h36;
                4:       cb = 8'h00;
                default: cb = 8'h55;
            endcase
            kv = ($urandom_range(0, 4) == 0) && !(cv && cb == 8'h16);
            kb = 8'($urandom);
            cycle(cv, cb, kv, kb);
        end
        idle(T + 4);

        compared++;
        if (expQ.size() != 0) begin
            mism++;
            $display("FAIL leftover_replies: got %0d pending, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
`default_nettype wire
